// File: rtl/sha_pkg.sv
// sha_pkg: definitions shared by sha_padder and hcu.
//   - state_t        : padder FSM states
//   - mode_t         : 32-bit (SHA-224/256) or 64-bit (SHA-384/512) word mode
//   - dbg_t          : snapshot of the padder control state, exported on the dbg port
//   - BLOCK_WORDS    : words per SHA block (16 in both modes)
//   - LEN_HI_IDX     : word index at which the length words start
//   - codec_of()     : pulls the multiformats codec out of tuser
//   - codec2mode()   : maps a codec to a word mode
package sha_pkg;

    localparam int TUSER_W   = 128;
    localparam int CODEC_POS = 0;
    localparam int CODEC_W   = 16;

    // Multiformats codes for the SHA-2 family.
    localparam logic [CODEC_W-1:0] CODEC_SHA2_256 = 16'h0012;
    localparam logic [CODEC_W-1:0] CODEC_SHA2_512 = 16'h0013;
    localparam logic [CODEC_W-1:0] CODEC_SHA2_384 = 16'h0020;
    localparam logic [CODEC_W-1:0] CODEC_SHA2_224 = 16'h1013;

    localparam int         BLOCK_WORDS = 16;
    localparam logic [3:0] LEN_HI_IDX  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PASS   = 3'd1,
        ST_HALF   = 3'd2,
        ST_PAD    = 3'd3,
        ST_LEN_HI = 3'd4,
        ST_LEN_LO = 3'd5
    } state_t;

    typedef enum logic {
        MODE_32 = 1'b0,
        MODE_64 = 1'b1
    } mode_t;

    typedef struct packed {
        state_t     state;
        logic [3:0] word_idx;
        logic       pad_pend;
        logic       held_last;
    } dbg_t;

    function automatic logic [CODEC_W-1:0] codec_of(input logic [TUSER_W-1:0] tuser);
        return tuser[CODEC_POS +: CODEC_W];
    endfunction

    // Unknown codecs fall back to 32-bit mode so the stream is still framed.
    function automatic mode_t codec2mode(input logic [CODEC_W-1:0] codec);
        mode_t m;
        case (codec)
            CODEC_SHA2_384, CODEC_SHA2_512: m = MODE_64;
            default:                        m = MODE_32;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pad_byte_insert.sv
// pad_byte_insert: combinational lane formatter.
// Keeps input byte lanes 0..k-1, places 0x80 at lane k (when ins_en and
// k < W), zeroes every lane above, and emits the result big-endian
// (lane 0 in the most significant byte of the word).
// Ports:
//   data   [63:0] : input bytes, lane 0 in [7:0]
//   k      [3:0]  : number of message bytes kept (0..8)
//   w64           : 1 = 8-byte word in [63:0], 0 = 4-byte word in [31:0]
//   ins_en        : allow the 0x80 marker to be placed
//   word   [63:0] : formatted word; [63:32] is zero when w64 = 0
module pad_byte_insert (
    input  logic [63:0] data,
    input  logic [3:0]  k,
    input  logic        w64,
    input  logic        ins_en,
    output logic [63:0] word
);

    logic [7:0] lane_b [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane_b[i] = 8'h00;
            if (4'(i) < k) begin
                lane_b[i] = data[8*i +: 8];
            end else if (4'(i) == k && ins_en) begin
                lane_b[i] = 8'h80;
            end
        end
    end

    always_comb begin
        word = '0;
        if (w64) begin
            for (int i = 0; i < 8; i++) begin
                word[56-8*i +: 8] = lane_b[i];
            end
        end else begin
            // Lanes 4..7 are not part of a 4-byte word, so k = 4 leaves no room
            // for the marker here.
            for (int i = 0; i < 4; i++) begin
                word[24-8*i +: 8] = lane_b[i];
            end
        end
    end

endmodule

// File: rtl/sha_padder.sv
// sha_padder: FIPS 180-4 message padder in front of hcu.
// Takes a byte stream (lane 0 first), emits one SHA message word per beat:
// message words, 0x80 marker, zero fill, then two length words that close a
// 16-word block. Word mode (32/64-bit) comes from the codec in tuser.
// Ports:
//   axis_aclk, reset                 : clock, synchronous active-high reset
//   s_axis_tdata/tkeep/tuser/tlast   : input bytes, byte enables, codec, end
//   s_axis_tvalid/tready             : input handshake
//   m_axis_tdata/tuser/tlast         : output word (big-endian), tuser, end
//   m_axis_tvalid/tready             : output handshake
//   err                              : sticky tkeep protocol error
//   dbg                              : control-state snapshot (dbg_t)
// Build option: SHA_PADDER_TKEEP_CHECK_EN enables the tkeep checker driving
// err; without it err is constant 0.
//
// Handshakes: a beat transfers on a rising edge where valid && ready. A
// source holds valid and payload steady until that edge; ready may depend
// combinationally on the peer's ready (s_axis_tready follows m_axis_tready)
// but never on valid.
module sha_padder
    import sha_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 64,
    parameter int C_M_AXIS_DATA_WIDTH = 64,
    parameter int C_AXIS_TUSER_WIDTH  = 128
) (
    input  logic                             axis_aclk,
    input  logic                             reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             err,
    output dbg_t                             dbg
);

    state_t      state, state_nxt;
    mode_t       mode_q, mode_eff;
    logic [63:0] byte_cnt, cnt_base;
    logic [63:0] hold_q;
    logic [3:0]  word_idx, idx_base, idx_inc;
    logic        pad_pend, held_last;

    logic        load, accept, emit, out_last, full_last;
    logic [63:0] out_word, word_a, word_b;
    logic [3:0]  keep_cnt, k_a, k_b;
    logic        ins_b;
    logic [66:0] bitlen;

    assign dbg = '{state: state, word_idx: word_idx, pad_pend: pad_pend, held_last: held_last};

    // The first beat is consumed in IDLE, so its mode comes straight from tuser.
    assign mode_eff = (state == ST_IDLE) ? codec2mode(codec_of(s_axis_tuser)) : mode_q;

    // Lane A: the whole beat (64-bit) or bytes 0..3 (32-bit).
    // Lane B: bytes 4..7, held for the HALF cycle in 32-bit mode.
    pad_byte_insert u_ins_a (
        .data   (s_axis_tdata),
        .k      (k_a),
        .w64    (mode_eff == MODE_64),
        .ins_en (1'b1),
        .word   (word_a)
    );

    pad_byte_insert u_ins_b (
        .data   ({32'h0, s_axis_tdata[63:32]}),
        .k      (k_b),
        .w64    (1'b0),
        .ins_en (ins_b),
        .word   (word_b)
    );

    // ---------------- state register ----------------
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state ----------------
    // After the word holding (or preceding) the marker, go straight to the
    // length words if the next index is LEN_HI_IDX and no marker word is
    // still owed; otherwise fill in PAD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_PASS: begin
                if (accept) begin
                    if (mode_eff == MODE_32) begin
                        state_nxt = ST_HALF;
                    end else if (s_axis_tlast) begin
                        state_nxt = (full_last || idx_inc != LEN_HI_IDX) ? ST_PAD : ST_LEN_HI;
                    end else begin
                        state_nxt = ST_PASS;
                    end
                end
            end
            ST_HALF: begin
                if (load) begin
                    if (held_last) begin
                        state_nxt = (pad_pend || idx_inc != LEN_HI_IDX) ? ST_PAD : ST_LEN_HI;
                    end else begin
                        state_nxt = ST_PASS;
                    end
                end
            end
            ST_PAD: begin
                if (load && idx_inc == LEN_HI_IDX) begin
                    state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (load) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (load) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- outputs / datapath select ----------------
    always_comb begin
        load          = !m_axis_tvalid || m_axis_tready;
        s_axis_tready = !reset && load && (state == ST_IDLE || state == ST_PASS);
        accept        = s_axis_tvalid && s_axis_tready;

        keep_cnt  = 4'($countones(s_axis_tkeep));
        full_last = s_axis_tlast && (keep_cnt == 4'd8);

        // Non-last beats use k = W so no marker lands inside the word.
        if (mode_eff == MODE_64) begin
            k_a = s_axis_tlast ? keep_cnt : 4'd8;
        end else begin
            k_a = (s_axis_tlast && keep_cnt < 4'd4) ? keep_cnt : 4'd4;
        end

        // Upper half: marker only if the message reaches into lanes 4..7.
        k_b   = 4'd4;
        ins_b = 1'b1;
        if (s_axis_tlast) begin
            if (keep_cnt >= 4'd4) begin
                k_b = keep_cnt - 4'd4;
            end else begin
                k_b   = 4'd0;
                ins_b = 1'b0;
            end
        end

        cnt_base = (state == ST_IDLE) ? 64'd0 : byte_cnt;
        idx_base = (state == ST_IDLE) ? 4'd0  : word_idx;
        idx_inc  = idx_base + 4'd1;
        bitlen   = {byte_cnt, 3'b000};

        emit     = 1'b0;
        out_word = '0;
        out_last = 1'b0;
        case (state)
            ST_IDLE, ST_PASS: begin
                emit     = accept;
                out_word = word_a;
            end
            ST_HALF: begin
                emit     = 1'b1;
                out_word = hold_q;
            end
            ST_PAD: begin
                emit = 1'b1;
                if (pad_pend) begin
                    out_word = (mode_q == MODE_64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                end
            end
            ST_LEN_HI: begin
                emit     = 1'b1;
                out_word = (mode_q == MODE_64) ? {61'h0, bitlen[66:64]} : {32'h0, bitlen[63:32]};
            end
            ST_LEN_LO: begin
                emit     = 1'b1;
                out_last = 1'b1;
                out_word = (mode_q == MODE_64) ? bitlen[63:0] : {32'h0, bitlen[31:0]};
            end
            default: begin
                emit = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            mode_q        <= MODE_32;
            m_axis_tuser  <= '0;
            byte_cnt      <= '0;
            word_idx      <= '0;
            hold_q        <= '0;
            pad_pend      <= 1'b0;
            held_last     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                if (state == ST_IDLE) begin
                    m_axis_tuser <= s_axis_tuser;
                    mode_q       <= mode_eff;
                end
                byte_cnt <= cnt_base + 64'(keep_cnt);
                if (mode_eff == MODE_32) begin
                    hold_q    <= word_b;
                    held_last <= s_axis_tlast;
                end
                // A full last beat leaves no room for the marker: owe a word.
                if (s_axis_tlast) begin
                    pad_pend <= full_last;
                end
            end
            if (load) begin
                m_axis_tvalid <= emit;
                m_axis_tlast  <= emit && out_last;
                if (emit) begin
                    m_axis_tdata <= out_word;
                    word_idx     <= idx_inc;
                end
                if (state == ST_PAD) begin
                    pad_pend <= 1'b0;
                end
            end
        end
    end

`ifdef SHA_PADDER_TKEEP_CHECK_EN
    logic bad_beat;
    assign bad_beat = (!s_axis_tlast && s_axis_tkeep != 8'hFF)
                    || ((s_axis_tkeep & (s_axis_tkeep + 8'd1)) != 8'h00);

    // Sticky within a message; the first beat of a new message restarts it.
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= (state == ST_IDLE) ? bad_beat : (err | bad_beat);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
